// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 peripheral: FSM states, default word
// width and the fixed clock polarity/phase of the bus.
package spi_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   localparam bit CPOL = 1'b0;
   localparam bit CPHA = 1'b0;

   typedef enum logic [1:0] {
      ST_WAIT_DESELECT,
      ST_IDLE,
      ST_ACTIVE
   } state_t;

endpackage

// File: rtl/spi_if.sv
// SPI pins plus the local transmit/receive handshake of the peripheral.
// The slave modport is the peripheral's view; master is the controller/host side.
interface spi_if
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

   logic                  i_sclk;
   logic                  i_cs_n;
   logic                  i_mosi;
   logic                  o_miso;
   logic                  o_miso_oe;
   logic [DATA_WIDTH-1:0] i_tx_data;
   logic                  i_tx_valid;
   logic                  o_tx_ready;
   logic [DATA_WIDTH-1:0] o_rx_data;
   logic                  o_rx_valid;
   logic                  o_tx_underrun;
   logic                  o_frame_abort;
   logic                  o_busy;

   modport slave (
      input  i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
      output o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid,
             o_tx_underrun, o_frame_abort, o_busy
   );

   modport master (
      output i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
      input  o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid,
             o_tx_underrun, o_frame_abort, o_busy
   );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, with registered rise/fall
// pulses aligned to the cycle in which the synchronized level changes.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Edges are taken from the last two stages so each pulse coincides with `level`.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         rise   <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
         fall   <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target: oversamples the bus in the i_clk domain, shifts words
// MSB-first both ways and buffers one transmit word.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   spi_if.slave bus
);

   localparam int CNT_W          = $clog2(DATA_WIDTH);
   localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic unused_sclk_level;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .i_clk(i_clk), .i_rst(i_rst), .din(bus.i_sclk),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .i_clk(i_clk), .i_rst(i_rst), .din(bus.i_cs_n),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );

   assign unused_sclk_level = sclk_level;

   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   mosi_s;

   always_ff @(posedge i_clk) begin
      if (i_rst) mosi_q <= '0;
      else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.i_mosi};
   end

   assign mosi_s = mosi_q[SYNC_STAGES-1];

   logic sample_edge, shift_edge;
   assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
   assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

   state_t                state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-2:0] rx_shift;
   logic [DATA_WIDTH-1:0] rx_next;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] buf_data;
   logic                  buf_full;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid, tx_underrun, frame_abort;
   logic                  load, accept;

   assign rx_next = {rx_shift, mosi_s};
   assign accept  = bus.i_tx_valid && !buf_full;

   // A word is pulled from the buffer on select and at every byte boundary.
   always_comb begin
      // NOTE: default first so every path assigns `load` and no latch is inferred.
      load = 1'b0;
      if (state == ST_IDLE)
         load = cs_fall;
      else if (state == ST_ACTIVE)
         load = !cs_rise && !sample_edge && shift_edge && (bit_cnt == '0);
   end

   // NOTE: payload register carries no reset; buf_full alone says whether it is meaningful.
   always_ff @(posedge i_clk) begin
      if (accept) buf_data <= bus.i_tx_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)       buf_full <= 1'b0;
      else if (accept) buf_full <= 1'b1;
      else if (load)   buf_full <= 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_WAIT_DESELECT;
         bit_cnt     <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_abort <= 1'b0;
         tx_underrun <= load && !buf_full;
         case (state)
            ST_WAIT_DESELECT: if (cs_level) state <= ST_IDLE;
            ST_IDLE: begin
               if (cs_fall) begin
                  state   <= ST_ACTIVE;
                  bit_cnt <= '0;
               end
            end
            ST_ACTIVE: begin
               // Deselect outranks a coincident clock edge.
               if (cs_rise) begin
                  state       <= ST_IDLE;
                  frame_abort <= (bit_cnt != '0);
               end else if (sample_edge) begin
                  rx_shift <= rx_next[DATA_WIDTH-2:0];
                  if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                     bit_cnt  <= '0;
                     rx_data  <= rx_next;
                     rx_valid <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (shift_edge && bit_cnt != '0) begin
                  tx_shift <= tx_shift << 1;
               end
            end
            default: state <= ST_WAIT_DESELECT;
         endcase
         if (load) tx_shift <= buf_full ? buf_data : '0;
      end
   end

   assign bus.o_busy        = (state == ST_ACTIVE);
   assign bus.o_miso_oe     = (state == ST_ACTIVE);
   assign bus.o_miso        = (state == ST_ACTIVE) && tx_shift[DATA_WIDTH-1];
   assign bus.o_tx_ready    = !buf_full;
   assign bus.o_rx_data     = rx_data;
   assign bus.o_rx_valid    = rx_valid;
   assign bus.o_tx_underrun = tx_underrun;
   assign bus.o_frame_abort = frame_abort;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a bit-level controller drives the pins and a
// word-level model of the peripheral predicts every output on every cycle.
module tb_spi_peripheral;

   localparam int W    = 8;
   localparam int S    = 2;
   localparam int HALF = 4;

   localparam int MS_WAIT   = 0;
   localparam int MS_IDLE   = 1;
   localparam int MS_ACTIVE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_if #(.DATA_WIDTH(W)) bus ();

   spi_peripheral #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit           m_live = 1'b0;
   int           m_state;
   int           m_bits;
   int           m_pos;
   logic [W-1:0] m_word, m_cur;
   logic [W-1:0] m_buf[$];
   bit           h_sclk[0:S], h_cs[0:S], h_mosi[0:S];
   logic         e_miso, e_oe, e_ready, e_rx_valid, e_underrun, e_abort, e_busy;
   logic [W-1:0] e_rx_data;

   task automatic model_load();
      if (m_buf.size() > 0) m_cur = m_buf.pop_front();
      else begin
         m_cur      = '0;
         e_underrun = 1'b1;
      end
      m_pos = 0;
   endtask

   initial begin : model
      forever begin : step
         bit s_r, s_f, c_r, c_f, c_lvl, m_in, acc;
         logic [W-1:0] acc_d;
         @(posedge clk);
         e_rx_valid = 1'b0;
         e_underrun = 1'b0;
         e_abort    = 1'b0;
         if (rst) begin
            m_live    = 1'b1;
            m_state   = MS_WAIT;
            m_bits    = 0;
            m_pos     = 0;
            m_word    = '0;
            m_cur     = '0;
            e_rx_data = '0;
            m_buf.delete();
            for (int k = 0; k <= S; k++) begin
               h_sclk[k] = 1'b0;
               h_cs[k]   = 1'b0;
               h_mosi[k] = 1'b0;
            end
         end else begin
            // Pins seen S cycles ago are what the peripheral acts on now.
            s_r   = h_sclk[S-1] && !h_sclk[S];
            s_f   = !h_sclk[S-1] && h_sclk[S];
            c_r   = h_cs[S-1] && !h_cs[S];
            c_f   = !h_cs[S-1] && h_cs[S];
            c_lvl = h_cs[S-1];
            m_in  = h_mosi[S-1];
            acc   = bus.i_tx_valid && (m_buf.size() == 0);
            acc_d = bus.i_tx_data;
            case (m_state)
               MS_WAIT: if (c_lvl) m_state = MS_IDLE;
               MS_IDLE: begin
                  if (c_f) begin
                     m_state = MS_ACTIVE;
                     m_bits  = 0;
                     model_load();
                  end
               end
               default: begin
                  if (c_r) begin
                     m_state = MS_IDLE;
                     if (m_bits != 0) e_abort = 1'b1;
                  end else if (s_r) begin
                     m_word = {m_word[W-2:0], m_in};
                     m_bits++;
                     if (m_bits == W) begin
                        e_rx_data  = m_word;
                        e_rx_valid = 1'b1;
                        m_bits     = 0;
                     end
                  end else if (s_f) begin
                     if (m_bits == 0) model_load();
                     else m_pos++;
                  end
               end
            endcase
            if (acc) m_buf.push_back(acc_d);
            for (int k = S; k > 0; k--) begin
               h_sclk[k] = h_sclk[k-1];
               h_cs[k]   = h_cs[k-1];
               h_mosi[k] = h_mosi[k-1];
            end
            h_sclk[0] = bus.i_sclk;
            h_cs[0]   = bus.i_cs_n;
            h_mosi[0] = bus.i_mosi;
         end
         e_busy  = (m_state == MS_ACTIVE);
         e_oe    = e_busy;
         e_miso  = e_busy ? m_cur[W-1-m_pos] : 1'b0;
         e_ready = (m_buf.size() == 0);
      end
   end

   // ---------------- per-cycle compare and pulse counters ----------------
   int n_rxv = 0, n_udr = 0, n_abt = 0;

   initial begin : compare
      wait (m_live);
      forever begin
         @(negedge clk);
         check("miso",      bus.o_miso,        e_miso);
         check("miso_oe",   bus.o_miso_oe,     e_oe);
         check("busy",      bus.o_busy,        e_busy);
         check("tx_ready",  bus.o_tx_ready,    e_ready);
         check("rx_data",   bus.o_rx_data,     e_rx_data);
         check("rx_valid",  bus.o_rx_valid,    e_rx_valid);
         check("underrun",  bus.o_tx_underrun, e_underrun);
         check("abort",     bus.o_frame_abort, e_abort);
         n_rxv += int'(bus.o_rx_valid);
         n_udr += int'(bus.o_tx_underrun);
         n_abt += int'(bus.o_frame_abort);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   // ---------------- controller-side drivers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [W-1:0] mosi_word, input int nbits, output logic [W-1:0] miso_word);
      miso_word = '0;
      for (int i = 0; i < nbits; i++) begin
         bus.i_mosi = mosi_word[W-1-i];
         tick(HALF);
         bus.i_sclk = 1'b1;
         miso_word  = {miso_word[W-2:0], bus.o_miso};
         tick(HALF);
         bus.i_sclk = 1'b0;
      end
   endtask

   task automatic deselect();
      tick(HALF);
      bus.i_cs_n = 1'b1;
      tick(2 * HALF);
   endtask

   task automatic push(input logic [W-1:0] d);
      int t = 0;
      while (!bus.o_tx_ready && t < 200) begin
         tick(1);
         t++;
      end
      check("push_ready_wait", 32'(t < 200), 1);
      bus.i_tx_data  = d;
      bus.i_tx_valid = 1'b1;
      tick(1);
      bus.i_tx_valid = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin : stimulus
      logic [W-1:0] b0, b1;
      int rxv0, udr0, abt0, t;
      bus.i_sclk     = 1'b0;
      bus.i_cs_n     = 1'b1;
      bus.i_mosi     = 1'b0;
      bus.i_tx_data  = '0;
      bus.i_tx_valid = 1'b0;
      tick(3);
      check("reset_tx_ready", bus.o_tx_ready,    1);
      check("reset_miso_oe",  bus.o_miso_oe,     0);
      check("reset_busy",     bus.o_busy,        0);
      check("reset_rx_data",  bus.o_rx_data,     0);
      check("reset_miso",     bus.o_miso,        0);
      rst = 1'b0;
      tick(6);

      // 1: single byte, 0xA5 out, 0x3C in
      push(8'hA5);
      rxv0 = n_rxv;
      bus.i_cs_n = 1'b0;
      fork
         spi_bits(8'h3C, 8, b0);
         begin tick(10); push(8'h0F); end
      join
      deselect();
      check("t1_miso_word", b0,              8'hA5);
      check("t1_rx_data",   bus.o_rx_data,   8'h3C);
      check("t1_rx_pulses", n_rxv - rxv0,    1);
      check("t1_tx_ready",  bus.o_tx_ready,  1);

      // 2: two-byte frame with refill during the first byte
      push(8'h81);
      rxv0 = n_rxv; udr0 = n_udr;
      bus.i_cs_n = 1'b0;
      fork
         begin spi_bits(8'h12, 8, b0); spi_bits(8'hC4, 8, b1); end
         begin tick(10); push(8'h7E); push(8'hC3); end
      join
      deselect();
      check("t2_miso_byte0", b0,            8'h81);
      check("t2_miso_byte1", b1,            8'h7E);
      check("t2_rx_pulses",  n_rxv - rxv0,  2);
      check("t2_rx_data",    bus.o_rx_data, 8'hC4);
      check("t2_underruns",  n_udr - udr0,  0);

      // 3: empty buffer at select
      rxv0 = n_rxv; udr0 = n_udr;
      bus.i_cs_n = 1'b0;
      fork
         spi_bits(8'h99, 8, b0);
         begin tick(12); push(8'h5A); end
      join
      deselect();
      check("t3_miso_word",  b0,            8'h00);
      check("t3_underruns",  n_udr - udr0,  1);
      check("t3_rx_data",    bus.o_rx_data, 8'h99);
      check("t3_rx_pulses",  n_rxv - rxv0,  1);

      // 4: partial frame aborted after 5 bits, then a clean 0xF0
      rxv0 = n_rxv; abt0 = n_abt;
      bus.i_cs_n = 1'b0;
      spi_bits(8'hFF, 5, b0);
      deselect();
      check("t4_abort_pulses", n_abt - abt0, 1);
      check("t4_no_rx_valid",  n_rxv - rxv0, 0);
      bus.i_cs_n = 1'b0;
      spi_bits(8'hF0, 8, b0);
      deselect();
      check("t4_rx_data", bus.o_rx_data, 8'hF0);

      // 5: reset mid-frame with CS held low
      rxv0 = n_rxv;
      bus.i_cs_n = 1'b0;
      spi_bits(8'hA0, 3, b0);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      spi_bits(8'hFF, 5, b0);
      tick(2);
      check("t5_no_rx_valid", n_rxv - rxv0,  0);
      check("t5_miso_oe",     bus.o_miso_oe, 0);
      check("t5_busy",        bus.o_busy,    0);
      deselect();
      bus.i_cs_n = 1'b0;
      spi_bits(8'h55, 8, b0);
      deselect();
      check("t5_rx_data",   bus.o_rx_data, 8'h55);
      check("t5_rx_pulses", n_rxv - rxv0,  1);

      // 6: new word offered in the cycle the buffer is consumed
      push(8'h22);
      bus.i_tx_data  = 8'h33;
      bus.i_tx_valid = 1'b1;
      bus.i_cs_n     = 1'b0;
      fork
         begin spi_bits(8'h00, 8, b0); spi_bits(8'h00, 8, b1); end
         begin
            t = 0;
            while (!bus.o_tx_ready && t < 20) begin
               tick(1);
               t++;
            end
            check("t6_consume_seen", 32'(t < 20), 1);
            tick(1);
            bus.i_tx_valid = 1'b0;
            check("t6_ready_after_accept", bus.o_tx_ready, 0);
            push(8'h44);
         end
      join
      deselect();
      check("t6_old_word_sent", b0, 8'h22);
      check("t6_new_word_next", b1, 8'h33);

      tick(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
